// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_param
// Brief    : Parametrised register file with two read ports, one write port,
//            optional write-to-read bypass, optional registered read stage
//            and optional hard-wired zero register.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr0,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic             rvalid
);

    // One extra bit so that DEPTH itself is representable (DEPTH may be 2**AW).
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    raddr_v [2];
    logic [WIDTH-1:0] rval    [2];
    logic             write_ok;

    // An address holds real storage only if it is in range and is not the
    // hard-wired zero register; this gates both writes and forwarding.
    function automatic logic addr_live(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_V) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign write_ok   = we && addr_live(waddr);
    assign raddr_v[0] = raddr0;
    assign raddr_v[1] = raddr1;

    // Storage array: cleared asynchronously, written on legal writes only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // Read value per port: zero for dead addresses, forwarded write data on
    // a same-cycle legal write when bypass is enabled, else the array entry.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rval[p] = '0;
            if (addr_live(raddr_v[p])) begin
                if ((BYPASS != 0) && write_ok && (raddr_v[p] == waddr)) begin
                    rval[p] = wdata;
                end else begin
                    rval[p] = mem[raddr_v[p]];
                end
            end
        end
    end

    if (READ_REG != 0) begin : g_rreg
        logic [WIDTH-1:0] rdata0_q;
        logic [WIDTH-1:0] rdata1_q;
        logic             rvalid_q;

        // Registered read stage: load on re, hold otherwise; rvalid marks loads.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rdata0_q <= '0;
                rdata1_q <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= re;
                if (re) begin
                    rdata0_q <= rval[0];
                    rdata1_q <= rval[1];
                end
            end
        end

        assign rdata0 = rdata0_q;
        assign rdata1 = rdata1_q;
        assign rvalid = rvalid_q;
    end else begin : g_comb
        // Read request has no meaning for combinational reads.
        logic unused_re;
        assign unused_re = re;

        assign rdata0 = rval[0];
        assign rdata1 = rval[1];
        assign rvalid = 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_param
// Brief    : Directed self-checking bench for reg_file_param. Three instances
//            share one stimulus bus:
//              dut_a : defaults (ZERO_REG=1, BYPASS=1, READ_REG=0)
//              dut_b : ZERO_REG=0, BYPASS=0, READ_REG=0
//              dut_c : DEPTH=12, ZERO_REG=1, BYPASS=1, READ_REG=1
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        re;
    logic [3:0]  raddr0;
    logic [3:0]  raddr1;

    logic [31:0] a_rd0, a_rd1, b_rd0, b_rd1, c_rd0, c_rd1;
    logic        a_rv, b_rv, c_rv;

    // Expected array contents of each instance.
    logic [31:0] ma [16];
    logic [31:0] mb [16];
    logic [31:0] mc [12];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_file_param #(.WIDTH(32), .DEPTH(16), .ZERO_REG(1), .BYPASS(1), .READ_REG(0)) dut_a (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
        .raddr0(raddr0), .raddr1(raddr1), .rdata0(a_rd0), .rdata1(a_rd1), .rvalid(a_rv)
    );

    reg_file_param #(.WIDTH(32), .DEPTH(16), .ZERO_REG(0), .BYPASS(0), .READ_REG(0)) dut_b (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
        .raddr0(raddr0), .raddr1(raddr1), .rdata0(b_rd0), .rdata1(b_rd1), .rvalid(b_rv)
    );

    reg_file_param #(.WIDTH(32), .DEPTH(12), .ZERO_REG(1), .BYPASS(1), .READ_REG(1)) dut_c (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
        .raddr0(raddr0), .raddr1(raddr1), .rdata0(c_rd0), .rdata1(c_rd1), .rvalid(c_rv)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record a write that commits at the next edge into the expected arrays.
    task automatic model_write(input logic [3:0] a, input logic [31:0] d);
        if (a != 0) ma[a] = d;
        mb[a] = d;
        if (a != 0 && a < 12) mc[a] = d;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        for (int i = 0; i < 12; i++) mc[i] = '0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
        model_write(a, d);
    endtask

    initial begin
        model_clear();
        rst = 1'b0; we = 1'b1; waddr = 4'd5; wdata = $urandom; re = 1'b1;
        raddr0 = 4'd5; raddr1 = 4'd6;

        // Writes and reads under reset must be ignored.
        repeat (3) begin
            wdata = $urandom;
            waddr = 4'($urandom_range(0, 15));
            tick();
        end
        check_eq("rst_c_rvalid", {31'b0, c_rv}, 32'd0);
        check_eq("rst_c_rdata0", c_rd0, 32'd0);
        check_eq("rst_c_rdata1", c_rd1, 32'd0);
        rst = 1'b1; we = 1'b0; re = 1'b0;

        for (int i = 0; i < 16; i++) begin
            raddr0 = 4'(i); raddr1 = 4'(15 - i);
            #1;
            check_eq($sformatf("rst_a_r%0d", i), a_rd0, 32'd0);
            check_eq($sformatf("rst_b_r%0d", i), b_rd1, 32'd0);
        end
        check_eq("a_rvalid_tied", {31'b0, a_rv}, 32'd1);
        tick();
        check_eq("rst_c_rvalid_idle", {31'b0, c_rv}, 32'd0);

        // Write then read on both ports.
        wr(4'd5, 32'hDEADBEEF);
        raddr0 = 4'd5; raddr1 = 4'd5; #1;
        check_eq("wr_a_p0", a_rd0, 32'hDEADBEEF);
        check_eq("wr_a_p1", a_rd1, 32'hDEADBEEF);
        check_eq("wr_b_p0", b_rd0, 32'hDEADBEEF);

        // Zero register.
        wr(4'd0, 32'h12345678);
        raddr0 = 4'd0; #1;
        check_eq("zero_a", a_rd0, 32'h0);
        check_eq("zero_b", b_rd0, 32'h12345678);

        // Bypass on a legal write.
        wr(4'd3, 32'h11);
        wr(4'd7, 32'h77);
        we = 1'b1; waddr = 4'd7; wdata = 32'hA5A5A5A5; raddr0 = 4'd7; raddr1 = 4'd3;
        #2;
        check_eq("byp_a_p0", a_rd0, 32'hA5A5A5A5);
        check_eq("byp_a_p1", a_rd1, 32'h11);
        check_eq("nobyp_b_p0", b_rd0, 32'h77);
        check_eq("nobyp_b_p1", b_rd1, 32'h11);
        tick(); we = 1'b0; model_write(4'd7, 32'hA5A5A5A5); #1;
        check_eq("after_b_p0", b_rd0, 32'hA5A5A5A5);

        // A write to the zero register is never forwarded.
        we = 1'b1; waddr = 4'd0; wdata = 32'hCAFE0000; raddr0 = 4'd0; raddr1 = 4'd0;
        #2;
        check_eq("byp_zero_a", a_rd0, 32'h0);
        check_eq("byp_zero_b_old", b_rd1, 32'h12345678);
        tick(); we = 1'b0; model_write(4'd0, 32'hCAFE0000); #1;
        check_eq("zero_b_new", b_rd0, 32'hCAFE0000);
        check_eq("zero_a_still", a_rd0, 32'h0);

        // Registered mode, DEPTH=12.
        wr(4'd11, 32'hBBBB0011);
        re = 1'b1; raddr0 = 4'd11; raddr1 = 4'd5;
        tick(); re = 1'b0;
        check_eq("c_r11", c_rd0, 32'hBBBB0011);
        check_eq("c_r5", c_rd1, 32'hDEADBEEF);
        check_eq("c_rvalid_hi", {31'b0, c_rv}, 32'd1);
        raddr0 = 4'd3;
        tick();
        check_eq("c_rvalid_lo", {31'b0, c_rv}, 32'd0);
        check_eq("c_hold", c_rd0, 32'hBBBB0011);

        re = 1'b1; raddr0 = 4'd13;
        tick(); re = 1'b0;
        check_eq("c_oor_read", c_rd0, 32'h0);
        check_eq("c_oor_rvalid", {31'b0, c_rv}, 32'd1);

        // Out-of-range write with a same-cycle read: dropped and not forwarded.
        we = 1'b1; waddr = 4'd13; wdata = 32'hFFFFFFFF; re = 1'b1; raddr0 = 4'd13;
        tick(); we = 1'b0; re = 1'b0; model_write(4'd13, 32'hFFFFFFFF);
        check_eq("c_oor_byp", c_rd0, 32'h0);
        for (int i = 0; i < 12; i++) begin
            re = 1'b1; raddr0 = 4'(i); raddr1 = 4'(11 - i);
            tick();
            check_eq($sformatf("c_scan_r%0d", i), c_rd0, mc[i]);
        end
        re = 1'b0;

        // Registered bypass: value written at the same edge is captured.
        we = 1'b1; waddr = 4'd4; wdata = 32'h44; re = 1'b1; raddr0 = 4'd4; raddr1 = 4'd5;
        tick(); we = 1'b0; model_write(4'd4, 32'h44);
        check_eq("c_reg_byp", c_rd0, 32'h44);

        // Back-to-back reads: rvalid stays high, one result per cycle.
        raddr0 = 4'd7; tick();
        check_eq("c_b2b_d0", c_rd0, 32'hA5A5A5A5);
        check_eq("c_b2b_v0", {31'b0, c_rv}, 32'd1);
        raddr0 = 4'd3; tick();
        check_eq("c_b2b_d1", c_rd0, 32'h11);
        check_eq("c_b2b_v1", {31'b0, c_rv}, 32'd1);

        // Mid-operation reset between edges.
        raddr0 = 4'd5; raddr1 = 4'd7;
        #2 rst = 1'b0;
        #1;
        model_clear();
        check_eq("mid_c_rdata0", c_rd0, 32'h0);
        check_eq("mid_c_rdata1", c_rd1, 32'h0);
        check_eq("mid_c_rvalid", {31'b0, c_rv}, 32'd0);
        check_eq("mid_a_rdata0", a_rd0, 32'h0);
        check_eq("mid_b_rdata1", b_rd1, 32'h0);
        #1 rst = 1'b1;
        tick(); re = 1'b0;
        check_eq("post_c_rvalid", {31'b0, c_rv}, 32'd1);
        check_eq("post_c_rdata0", c_rd0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
